ssm_funnel_demux: RTL and testbench

//  Upstream feeder for the four per-substream bitparse instances of the VDC-M decoder.

---
 rtl/vdcm_ssm_pkg.sv | 25 ++
 rtl/ssm_word_fifo.sv | 47 ++++
 rtl/ssm_funnel_demux.sv | 153 +++++++++++++++
 tb/tb_ssm_funnel_demux.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/vdcm_ssm_pkg.sv
// Shared constants and types for the VDC-M substream funnel/demux.
package vdcm_ssm_pkg;

  localparam int unsigned NUM_SSM    = 4;
  localparam int unsigned MUX_WORD_W = 128;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned INIT_WORDS = 1;

  localparam int unsigned SSM_IDX_W   = $clog2(NUM_SSM);
  localparam int unsigned FIFO_CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PF_TOTAL    = NUM_SSM * INIT_WORDS;
  localparam int unsigned PF_CNT_W    = $clog2(PF_TOTAL + 1);
  localparam int unsigned REQ_DEPTH   = NUM_SSM * FIFO_DEPTH;
  localparam int unsigned REQ_AW      = $clog2(REQ_DEPTH);
  localparam int unsigned PUSH_CNT_W  = $clog2(NUM_SSM + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    RUN     = 2'd2
  } demux_state_t;

  typedef logic [SSM_IDX_W-1:0] ssm_idx_t;

endpackage

// File: rtl/ssm_word_fifo.sv
// Synchronous show-ahead word FIFO; head is valid whenever o_empty is low.
module ssm_word_fifo #(
  parameter int unsigned W     = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_flush,
  input  logic                    i_wr,
  input  logic [W-1:0]            i_wdata,
  input  logic                    i_rd,
  output logic [W-1:0]            o_head,
  output logic                    o_empty,
  output logic                    o_full,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (i_rd && !o_empty) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/ssm_funnel_demux.sv
// Feeds the per-substream bitparse FIFOs from a single mux-word stream,
// dispatching words in the order the parsers consumed them.
module ssm_funnel_demux
  import vdcm_ssm_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_dec,
  input  logic [MUX_WORD_W-1:0]         in_data,
  input  logic                          in_vld,
  output logic                          in_rdy,
  input  logic [NUM_SSM-1:0]            ssm_rd_en,
  output logic [NUM_SSM*MUX_WORD_W-1:0] ssm_data,
  output logic [NUM_SSM-1:0]            ssm_vld,
  output logic                          busy,
  output logic                          underflow
);

  demux_state_t           r_state;
  demux_state_t           w_state_nxt;
  logic [PF_CNT_W-1:0]    r_pf_cnt;
  logic                   r_underflow;

  ssm_idx_t               r_req_q [REQ_DEPTH];
  logic [REQ_AW-1:0]      r_req_rd;
  logic [REQ_AW-1:0]      r_req_wr;
  logic [REQ_AW:0]        r_req_cnt;
  logic [REQ_AW+1:0]      w_req_cnt_nxt;
  logic [REQ_AW-1:0]      w_push_ofs [NUM_SSM];
  logic [PUSH_CNT_W-1:0]  w_push_cnt;
  logic                   w_req_pop;

  logic                   w_acc;
  ssm_idx_t               w_tgt;
  logic [NUM_SSM-1:0]     w_pop;
  logic [NUM_SSM-1:0]     w_wr;
  logic [NUM_SSM-1:0]     w_empty;
  logic [NUM_SSM-1:0]     w_full;
  logic [MUX_WORD_W-1:0]  w_head  [NUM_SSM];
  logic [FIFO_CNT_W-1:0]  w_count [NUM_SSM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and input-ready; start_dec overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    in_rdy      = 1'b0;
    case (r_state)
      IDLE: begin
        in_rdy = 1'b0;
      end
      PREFILL: begin
        in_rdy = 1'b1;
        if (in_vld && (r_pf_cnt == PF_CNT_W'(PF_TOTAL - 1))) w_state_nxt = RUN;
      end
      RUN: begin
        in_rdy = (r_req_cnt != '0);
      end
      default: w_state_nxt = IDLE;
    endcase
    if (start_dec) w_state_nxt = PREFILL;
  end

  assign w_acc     = in_vld && in_rdy && !start_dec;
  assign w_req_pop = w_acc && (r_state == RUN);
  assign w_tgt     = (r_state == RUN) ? r_req_q[r_req_rd]
                                      : ssm_idx_t'(r_pf_cnt % PF_CNT_W'(NUM_SSM));
  assign busy      = (r_state != IDLE);
  assign underflow = r_underflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pf_cnt    <= '0;
      r_underflow <= 1'b0;
    end else if (start_dec) begin
      r_pf_cnt    <= '0;
      r_underflow <= 1'b0;
    end else begin
      if ((r_state == PREFILL) && w_acc) r_pf_cnt <= r_pf_cnt + PF_CNT_W'(1);
      if (|(ssm_rd_en & ~ssm_vld)) r_underflow <= 1'b1;
    end
  end

  // Simultaneous pops land in ascending SSM order behind the write pointer.
  always_comb begin
    w_push_cnt = '0;
    for (int i = 0; i < int'(NUM_SSM); i++) begin
      w_push_ofs[i] = REQ_AW'(w_push_cnt);
      w_push_cnt    = w_push_cnt + PUSH_CNT_W'(w_pop[i]);
    end
  end

  assign w_req_cnt_nxt = (REQ_AW+2)'(r_req_cnt) + (REQ_AW+2)'(w_push_cnt)
                       - (REQ_AW+2)'(w_req_pop);

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_SSM); i++) begin
      if (w_pop[i]) r_req_q[REQ_AW'(r_req_wr + w_push_ofs[i])] <= ssm_idx_t'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_rd  <= '0;
      r_req_wr  <= '0;
      r_req_cnt <= '0;
    end else if (start_dec) begin
      r_req_rd  <= '0;
      r_req_wr  <= '0;
      r_req_cnt <= '0;
    end else begin
      r_req_rd  <= r_req_rd + REQ_AW'(w_req_pop);
      r_req_wr  <= r_req_wr + REQ_AW'(w_push_cnt);
      r_req_cnt <= (REQ_AW+1)'(w_req_cnt_nxt);
    end
  end

  a_req_no_overflow: assert property (@(posedge clk) disable iff (rst)
    w_req_cnt_nxt <= (REQ_AW+2)'(REQ_DEPTH));

  for (genvar i = 0; i < int'(NUM_SSM); i++) begin : g_ssm
    assign w_pop[i] = ssm_rd_en[i] && !w_empty[i] && !start_dec;
    assign w_wr[i]  = w_acc && (w_tgt == ssm_idx_t'(i));

    ssm_word_fifo #(
      .W     (MUX_WORD_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (start_dec),
      .i_wr    (w_wr[i]),
      .i_wdata (in_data),
      .i_rd    (w_pop[i]),
      .o_head  (w_head[i]),
      .o_empty (w_empty[i]),
      .o_full  (w_full[i]),
      .o_count (w_count[i])
    );

    assign ssm_data[i*MUX_WORD_W +: MUX_WORD_W] = w_head[i];
    assign ssm_vld[i] = !w_empty[i];

    a_fifo_no_overrun: assert property (@(posedge clk) disable iff (rst)
      !(w_wr[i] && w_full[i] && !w_pop[i]));
    a_fifo_count_ok: assert property (@(posedge clk) disable iff (rst)
      w_count[i] <= FIFO_CNT_W'(FIFO_DEPTH));
  end

endmodule

// File: tb/tb_ssm_funnel_demux.sv
// Randomized bench for ssm_funnel_demux against a queue-based reference model.
module tb_ssm_funnel_demux;
  import vdcm_ssm_pkg::*;

  localparam int unsigned W = MUX_WORD_W;

  logic               clk;
  logic               rst;
  logic               start_dec;
  logic [W-1:0]       in_data;
  logic               in_vld;
  logic               in_rdy;
  logic [NUM_SSM-1:0] ssm_rd_en;
  logic [NUM_SSM*W-1:0] ssm_data;
  logic [NUM_SSM-1:0] ssm_vld;
  logic               busy;
  logic               underflow;

  int n_checks;
  int n_errors;

  typedef enum {M_IDLE, M_PREFILL, M_RUN} m_state_e;

  m_state_e     m_st;
  logic [W-1:0] m_fifo [NUM_SSM][FIFO_DEPTH];
  int           m_cnt  [NUM_SSM];
  int           m_req  [$];
  int           m_pf;
  bit           m_uf;

  ssm_funnel_demux dut (
    .clk       (clk),
    .rst       (rst),
    .start_dec (start_dec),
    .in_data   (in_data),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .ssm_rd_en (ssm_rd_en),
    .ssm_data  (ssm_data),
    .ssm_vld   (ssm_vld),
    .busy      (busy),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_rdy();
    return (m_st == M_PREFILL) || ((m_st == M_RUN) && (m_req.size() > 0));
  endfunction

  task automatic model_reset();
    m_st = M_IDLE;
    m_pf = 0;
    m_uf = 1'b0;
    m_req.delete();
    for (int i = 0; i < int'(NUM_SSM); i++) m_cnt[i] = 0;
  endtask

  task automatic check_all();
    check_val("in_rdy", W'(in_rdy), W'(exp_rdy()));
    check_val("busy", W'(busy), W'(m_st != M_IDLE));
    check_val("underflow", W'(underflow), W'(m_uf));
    for (int i = 0; i < int'(NUM_SSM); i++) begin
      check_val($sformatf("ssm_vld%0d", i), W'(ssm_vld[i]), W'(m_cnt[i] > 0));
      if (m_cnt[i] > 0)
        check_val($sformatf("ssm_data%0d", i), ssm_data[i*W +: W], m_fifo[i][0]);
    end
  endtask

  task automatic check_reset_outputs();
    check_val("rst_in_rdy", W'(in_rdy), '0);
    check_val("rst_busy", W'(busy), '0);
    check_val("rst_underflow", W'(underflow), '0);
    check_val("rst_ssm_vld", W'(ssm_vld), '0);
    for (int i = 0; i < int'(NUM_SSM); i++)
      check_val($sformatf("rst_ssm_data%0d", i), ssm_data[i*W +: W], '0);
  endtask

  // Drive one cycle of random stimulus and advance the model to the next edge.
  task automatic drive_and_model();
    bit           sd;
    bit           iv;
    bit           acc;
    int           tgt;
    logic [W-1:0] d;
    logic [NUM_SSM-1:0] rd;

    sd = (m_st == M_IDLE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
    iv = ($urandom_range(0, 3) != 0);
    d  = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 0; i < int'(NUM_SSM); i++)
      rd[i] = (m_cnt[i] > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 2);

    start_dec = sd;
    in_vld    = iv;
    in_data   = d;
    ssm_rd_en = rd;

    if (sd) begin
      model_reset();
      m_st = M_PREFILL;
    end else begin
      acc = iv && exp_rdy();
      tgt = -1;
      if (acc) begin
        if (m_st == M_PREFILL) tgt = m_pf % int'(NUM_SSM);
        else                   tgt = m_req.pop_front();
      end
      for (int i = 0; i < int'(NUM_SSM); i++) begin
        if (rd[i]) begin
          if (m_cnt[i] > 0) begin
            for (int k = 0; k < int'(FIFO_DEPTH) - 1; k++) m_fifo[i][k] = m_fifo[i][k+1];
            m_cnt[i]--;
            m_req.push_back(i);
          end else begin
            m_uf = 1'b1;
          end
        end
      end
      if (tgt >= 0 && m_cnt[tgt] < int'(FIFO_DEPTH)) begin
        m_fifo[tgt][m_cnt[tgt]] = d;
        m_cnt[tgt]++;
      end
      if (m_st == M_PREFILL && acc) begin
        m_pf++;
        if (m_pf == int'(NUM_SSM * INIT_WORDS)) m_st = M_RUN;
      end
    end
  endtask

  // Asynchronous reset pulse in the middle of a cycle; outputs must clear at once.
  task automatic async_reset_pulse();
    in_vld    = 1'b1;
    start_dec = 1'b0;
    ssm_rd_en = NUM_SSM'($urandom());
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    start_dec = 1'b0;
    in_vld    = 1'b1;
    in_data   = '0;
    ssm_rd_en = '0;
    model_reset();
    #1 rst = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Idle with valid data offered: nothing may be accepted before start_dec.
    in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_all();
    end

    for (int c = 0; c < 4000; c++) begin
      drive_and_model();
      @(negedge clk);
      check_all();
      if ($urandom_range(0, 299) == 0) begin
        async_reset_pulse();
        check_all();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
